// File: rtl/slave_bridge.sv
// CPU-to-slave-microcontroller bridge: latches the CPU access onto the slave ports,
// pulses the slave IRQ, waits for slave DTACK and returns the slave byte to the CPU.
// Optional macro SLAVE_BRIDGE_TIMEOUT_EN adds a forced termination when DTACK never arrives.
//
// state      | meaning
// IDLE       | waiting for cs with a byte strobe
// DELAY      | counting IRQ_DELAY clocks before the slave IRQ pulse
// WAIT_DTACK | waiting for a rising edge on the slave DTACK line
// ACK        | one-cycle bus_ack to the CPU
// RELEASE    | waiting for cs to drop so a held strobe cannot retrigger
module slave_bridge #(
    parameter int IRQ_DELAY = 20,
    parameter int TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [6:0]  cpu_addr,
    input  logic [15:0] cpu_din,
    input  logic        cpu_uds,
    input  logic        cpu_lds,
    input  logic        cpu_write_strobe,
    output logic [15:0] cpu_dout,
    output logic        bus_ack,
    output logic [7:0]  uc_porta_in,
    input  logic [7:0]  uc_porta_out,
    output logic [1:0]  uc_portc_addr,
    output logic        uc_portd_rw,
    output logic        uc_irq_n,
    input  logic        dtackslaven,
    input  logic        in2in,
    output logic        cpu_in2
);

    typedef enum logic [2:0] {IDLE, DELAY, WAIT_DTACK, ACK, RELEASE} state_t;

    state_t      state;
    logic [7:0]  dly_cnt;
    logic        dtack_q;
    logic        dtack_rise;
    logic        unused_bits;
`ifdef SLAVE_BRIDGE_TIMEOUT_EN
    logic [15:0] to_cnt;
`endif

    assign dtack_rise  = dtackslaven & ~dtack_q;
    assign unused_bits = ^{cpu_addr[6:2], cpu_din[15:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            dly_cnt       <= 8'd0;
            dtack_q       <= 1'b0;
            bus_ack       <= 1'b0;
            uc_irq_n      <= 1'b1;
            cpu_dout      <= 16'h0000;
            uc_porta_in   <= 8'hFF;
            uc_portc_addr <= 2'b11;
            uc_portd_rw   <= 1'b1;
            cpu_in2       <= 1'b0;
`ifdef SLAVE_BRIDGE_TIMEOUT_EN
            to_cnt        <= 16'd0;
`endif
        end else begin
            dtack_q  <= dtackslaven;
            cpu_in2  <= ~in2in;
            bus_ack  <= 1'b0;
            uc_irq_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (cs && (cpu_uds || cpu_lds)) begin
                        uc_porta_in   <= cpu_din[7:0];
                        uc_portc_addr <= cpu_addr[1:0];
                        uc_portd_rw   <= ~cpu_write_strobe;
                        dly_cnt       <= 8'(IRQ_DELAY);
                        state         <= DELAY;
                    end
                end
                DELAY: begin
                    dly_cnt <= dly_cnt - 8'd1;
                    // Abort takes priority so a pending IRQ pulse is never issued.
                    if (!cs) begin
                        state <= IDLE;
                    end else if (dly_cnt == 8'd1) begin
                        uc_irq_n <= 1'b0;
                        state    <= WAIT_DTACK;
`ifdef SLAVE_BRIDGE_TIMEOUT_EN
                        to_cnt   <= 16'(TIMEOUT);
`endif
                    end
                end
                WAIT_DTACK: begin
                    if (!cs) begin
                        state <= IDLE;
                    end else if (dtack_rise) begin
                        cpu_dout <= {uc_porta_out, uc_porta_out};
                        state    <= ACK;
                    end
`ifdef SLAVE_BRIDGE_TIMEOUT_EN
                    else if (to_cnt == 16'd1) begin
                        to_cnt   <= 16'd0;
                        cpu_dout <= 16'hFFFF;
                        state    <= ACK;
                    end else begin
                        to_cnt <= to_cnt - 16'd1;
                    end
`endif
                end
                ACK: begin
                    bus_ack <= 1'b1;
                    state   <= RELEASE;
                end
                RELEASE: begin
                    if (!cs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slave_bridge.sv
// Directed bench for slave_bridge (default build, IRQ_DELAY=20): read, write, aborts,
// mid-access reset, ignored DTACK edges and the indefinite DTACK wait.
module tb_slave_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic [6:0]  cpu_addr;
    logic [15:0] cpu_din;
    logic        cpu_uds;
    logic        cpu_lds;
    logic        cpu_write_strobe;
    logic [15:0] cpu_dout;
    logic        bus_ack;
    logic [7:0]  uc_porta_in;
    logic [7:0]  uc_porta_out;
    logic [1:0]  uc_portc_addr;
    logic        uc_portd_rw;
    logic        uc_irq_n;
    logic        dtackslaven;
    logic        in2in;
    logic        cpu_in2;

    int n_cmp = 0;
    int n_bad = 0;
    int irq_cnt, irq_at, ack_cnt, ack_at;
    logic [15:0] dout_ack;

    slave_bridge dut (
        .clk              (clk),
        .reset            (reset),
        .cs               (cs),
        .cpu_addr         (cpu_addr),
        .cpu_din          (cpu_din),
        .cpu_uds          (cpu_uds),
        .cpu_lds          (cpu_lds),
        .cpu_write_strobe (cpu_write_strobe),
        .cpu_dout         (cpu_dout),
        .bus_ack          (bus_ack),
        .uc_porta_in      (uc_porta_in),
        .uc_porta_out     (uc_porta_out),
        .uc_portc_addr    (uc_portc_addr),
        .uc_portd_rw      (uc_portd_rw),
        .uc_irq_n         (uc_irq_n),
        .dtackslaven      (dtackslaven),
        .in2in            (in2in),
        .cpu_in2          (cpu_in2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".bus_ack"},  32'(bus_ack),       32'h0);
        check({tag, ".irq_n"},    32'(uc_irq_n),      32'h1);
        check({tag, ".dout"},     32'(cpu_dout),      32'h0);
        check({tag, ".porta_in"}, 32'(uc_porta_in),   32'hFF);
        check({tag, ".portc"},    32'(uc_portc_addr), 32'h3);
        check({tag, ".rw"},       32'(uc_portd_rw),   32'h1);
        check({tag, ".in2"},      32'(cpu_in2),       32'h0);
    endtask

    // Cycle n is the state just after the n-th edge following the start edge.
    // dtack rises / cs drops right after edge dt_at / cs_drop_at (0 = never).
    task automatic run(input int ncyc, input int dt_at, input int cs_drop_at);
        irq_cnt = 0; irq_at = -1; ack_cnt = 0; ack_at = -1; dout_ack = 16'h0;
        for (int n = 1; n <= ncyc; n++) begin
            step();
            if (!uc_irq_n) begin irq_cnt++; irq_at = n; end
            if (bus_ack)   begin ack_cnt++; ack_at = n; dout_ack = cpu_dout; end
            if (n == dt_at)      dtackslaven = 1'b1;
            if (n == cs_drop_at) cs = 1'b0;
        end
    endtask

    task automatic start(input logic [6:0] a, input logic [15:0] d, input logic wr);
        cpu_addr = a; cpu_din = d; cpu_write_strobe = wr;
        cpu_lds = 1'b1; cpu_uds = 1'b0; cs = 1'b1;
        step();
    endtask

    task automatic idle_bus();
        cs = 1'b0; cpu_lds = 1'b0; cpu_uds = 1'b0; dtackslaven = 1'b0;
        step(); step();
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_uds = 1'b0; cpu_lds = 1'b0;
        cpu_write_strobe = 1'b0; uc_porta_out = 8'h00; dtackslaven = 1'b0; in2in = 1'b1;
        step(); step(); step();
        check_reset_values("rst");
        reset = 1'b0;

        in2in = 1'b0; step();
        check("in2_low", 32'(cpu_in2), 32'h1);
        in2in = 1'b1; step();
        check("in2_high", 32'(cpu_in2), 32'h0);

        // Read, byte address 0x02, slave answers 0x5A ten clocks after the IRQ pulse.
        uc_porta_out = 8'h5A;
        start(7'h01, 16'h1234, 1'b0);
        check("rd.rw",    32'(uc_portd_rw),   32'h1);
        check("rd.portc", 32'(uc_portc_addr), 32'h1);
        check("rd.porta", 32'(uc_porta_in),   32'h34);
        run(40, 30, 0);
        check("rd.irq_cnt", 32'(irq_cnt), 32'd1);
        check("rd.irq_at",  32'(irq_at),  32'd20);
        check("rd.ack_cnt", 32'(ack_cnt), 32'd1);
        check("rd.ack_at",  32'(ack_at),  32'd32);
        check("rd.dout",    32'(dout_ack), 32'h5A5A);
        idle_bus();
        check("rd.hold", 32'(cpu_dout), 32'h5A5A);

        // Write 0x00C3 at byte address 0x04; inputs change mid-access, ports must not.
        start(7'h02, 16'h00C3, 1'b1);
        check("wr.porta", 32'(uc_porta_in),   32'hC3);
        check("wr.portc", 32'(uc_portc_addr), 32'h2);
        check("wr.rw",    32'(uc_portd_rw),   32'h0);
        cpu_din = 16'hFFFF; cpu_addr = 7'h00; cpu_write_strobe = 1'b0;
        run(40, 25, 0);
        check("wr.ack_cnt", 32'(ack_cnt), 32'd1);
        check("wr.ack_at",  32'(ack_at),  32'd27);
        check("wr.porta_held", 32'(uc_porta_in),   32'hC3);
        check("wr.portc_held", 32'(uc_portc_addr), 32'h2);
        check("wr.rw_held",    32'(uc_portd_rw),   32'h0);
        idle_bus();

        // Abort in DELAY: cs seen low at clock 5; the later DTACK edge lands in IDLE.
        uc_porta_out = 8'h11;
        start(7'h01, 16'h0000, 1'b0);
        run(40, 30, 4);
        check("abd.irq_cnt", 32'(irq_cnt), 32'd0);
        check("abd.ack_cnt", 32'(ack_cnt), 32'd0);
        check("abd.dout",    32'(cpu_dout), 32'h5A5A);
        idle_bus();

        // cs seen low exactly on the IRQ cycle: pulse suppressed.
        start(7'h01, 16'h0000, 1'b0);
        run(30, 0, 19);
        check("abi.irq_cnt", 32'(irq_cnt), 32'd0);
        check("abi.irq_n",   32'(uc_irq_n), 32'h1);
        idle_bus();

        // Abort in WAIT_DTACK; the DTACK edge afterwards is ignored.
        start(7'h01, 16'h0000, 1'b0);
        run(40, 30, 24);
        check("abw.irq_at",  32'(irq_at),  32'd20);
        check("abw.ack_cnt", 32'(ack_cnt), 32'd0);
        check("abw.dout",    32'(cpu_dout), 32'h5A5A);
        idle_bus();

        // Reset during WAIT_DTACK, then the held access restarts and completes.
        uc_porta_out = 8'h77;
        start(7'h01, 16'h00AB, 1'b0);
        run(24, 0, 0);
        reset = 1'b1;
        step();
        check_reset_values("rstw");
        reset = 1'b0;
        step();
        check("rstw.porta", 32'(uc_porta_in), 32'hAB);
        run(40, 30, 0);
        check("rstw.irq_at",  32'(irq_at),  32'd20);
        check("rstw.ack_cnt", 32'(ack_cnt), 32'd1);
        check("rstw.ack_at",  32'(ack_at),  32'd32);
        check("rstw.dout",    32'(dout_ack), 32'h7777);
        idle_bus();

        // DTACK never rises: no forced termination in the default build.
        start(7'h01, 16'h0000, 1'b0);
        run(10000, 0, 0);
        check("noto.irq_cnt", 32'(irq_cnt), 32'd1);
        check("noto.ack_cnt", 32'(ack_cnt), 32'd0);
        idle_bus();
        check("noto.dout", 32'(cpu_dout), 32'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/slave_bridge.md
SLAVE_BRIDGE -- requirements
Module: slave_bridge

Interface
REQ-001 Parameter IRQ_DELAY, default 20: clocks from access start to the slave IRQ pulse, legal range 1..255.
REQ-002 Parameter TIMEOUT, default 4096: clocks waited for slave DTACK before forced termination, legal range 16..65535.
REQ-003 clk  in  1  system clock; reset  in  1  synchronous, active-high reset.
REQ-004 cs  in  1  CPU select, 0x31xxxx window; cpu_addr  in  7  CPU address bits [7:1].
REQ-005 cpu_din  in  16  CPU write data; cpu_uds, cpu_lds  in  1 each  byte strobes; cpu_write_strobe  in  1  1 = write.
REQ-006 cpu_dout  out  16  read data returned to CPU; bus_ack  out  1  one-cycle access-complete strobe.
REQ-007 uc_porta_in  out  8  latched write byte presented to slave port A; uc_porta_out  in  8  slave port A output.
REQ-008 uc_portc_addr  out  2  latched cpu_addr[2:1]; uc_portd_rw  out  1  latched !cpu_write_strobe.
REQ-009 uc_irq_n  out  1  active-low slave interrupt; dtackslaven  in  1  slave DTACK line (port B bit 6 after DDR).
REQ-010 in2in  in  1  slave-to-CPU interrupt line, active low; cpu_in2  out  1  registered active-high CPU IN2.

Function
REQ-011 An access starts when cs=1 and (cpu_uds or cpu_lds)=1 in state IDLE.
REQ-012 FSM states SHALL be exactly IDLE, DELAY, WAIT_DTACK, ACK and RELEASE.
REQ-013 On access start: latch cpu_din[7:0], cpu_addr[2:1] and !cpu_write_strobe into the port outputs; load the delay counter with IRQ_DELAY; enter DELAY.
REQ-014 DELAY: decrement the counter each clock; on the cycle the counter equals 1, drive uc_irq_n=0 for exactly one clock and enter WAIT_DTACK.
REQ-015 WAIT_DTACK: a rising edge of dtackslaven (current 1, previous-cycle registered value 0) latches {uc_porta_out, uc_porta_out} into cpu_dout and enters ACK.
REQ-016 A dtackslaven rising edge observed in IDLE, DELAY, ACK or RELEASE SHALL be ignored.
REQ-017 ACK: bus_ack=1 for exactly one clock, then enter RELEASE.
REQ-018 RELEASE: hold until cs=0, then enter IDLE; this prevents retriggering on a held strobe.
REQ-019 cs dropping to 0 in DELAY or WAIT_DTACK aborts the access to IDLE with no bus_ack and uc_irq_n=1.
REQ-020 If the IRQ pulse of REQ-014 is still pending when cs drops, the pulse SHALL be suppressed.
REQ-021 cpu_dout SHALL hold its last latched value between accesses.
REQ-022 Port outputs SHALL change only on access start.
REQ-023 cpu_in2 SHALL equal !in2in delayed by one register stage, independent of FSM state.
REQ-024 Total read latency from access start = IRQ_DELAY + 1 + (clocks to DTACK edge) + 1.

Reset
REQ-025 Reset forces state IDLE and clears all counters and the dtackslaven history register.
REQ-026 Reset values: bus_ack=0, uc_irq_n=1, cpu_dout=0, uc_porta_in=0xFF, uc_portc_addr=2'b11, uc_portd_rw=1, cpu_in2=0.
REQ-027 Reset asserted mid-access SHALL abandon the access with no bus_ack and no IRQ pulse.

Configuration
REQ-028 Macro SLAVE_BRIDGE_TIMEOUT_EN defined: a counter loaded with TIMEOUT on WAIT_DTACK entry decrements each clock; at 0, enter ACK with cpu_dout=0xFFFF.
REQ-029 Macro SLAVE_BRIDGE_TIMEOUT_EN undefined: WAIT_DTACK waits indefinitely and no timeout logic is synthesized.

Verification
REQ-030 Read: cs=1, lds=1, addr=0x02, IRQ_DELAY=20; slave sets porta_out=0x5A and raises DTACK 10 clocks after the IRQ pulse -> uc_irq_n low exactly once, 20 clocks after start; bus_ack one clock, 32 clocks after start; cpu_dout=0x5A5A.
REQ-031 Write 0x00C3 at addr 0x04 -> uc_porta_in=0xC3, uc_portc_addr=2'b10, uc_portd_rw=0 from the cycle after start; single bus_ack after DTACK.
REQ-032 Abort: cs dropped in DELAY at clock 5 -> no IRQ pulse, no bus_ack, FSM in IDLE.
REQ-033 Abort: cs dropped in WAIT_DTACK -> no bus_ack; a later DTACK edge is ignored.
REQ-034 Reset pulsed during WAIT_DTACK -> all outputs at REQ-026 values the next clock; a following access completes normally.
REQ-035 With SLAVE_BRIDGE_TIMEOUT_EN and TIMEOUT=16, DTACK held low -> bus_ack with cpu_dout=0xFFFF 16 clocks after WAIT_DTACK entry; without the macro -> no bus_ack after 10000 clocks.
